// File: rtl/rfnoc_stream_pkg.sv
// Shared stream helpers for the serial link (axi_serializer / axi_deserializer):
// stats counter width, serializer state encoding and a width-generic bit reverse.
package rfnoc_stream_pkg;

    localparam int STATS_W = 16;
    localparam int MAX_W   = 1024;
    localparam int MAX_AW  = $clog2(MAX_W);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Reverses the low n bits of x; bits at and above n come back as zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) r[MAX_AW'(i)] = x[MAX_AW'(n - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_serializer.sv
// WIDTH-bit AXI-Stream to 1-bit AXI-Stream, MSB first, no bubbles between words.
// Define AXI_SERIALIZER_STATS_EN to add the words_sent / pkts_sent counters.
module axi_serializer
    import rfnoc_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reverse_input,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic             o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
`ifdef AXI_SERIALIZER_STATS_EN
    ,
    output logic [STATS_W-1:0] words_sent,
    output logic [STATS_W-1:0] pkts_sent
`endif
);

    localparam int CW = $clog2(WIDTH);

    ser_state_e       state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last, last_n;

    logic             busy, last_bit, xfer, load;
    logic [WIDTH-1:0] rev_data;

    assign busy     = (state == ST_SHIFT);
    assign last_bit = (cnt == '0);
    assign xfer     = busy & o_tready;
    // Combinational o_tready path lets the next word load on the final bit.
    assign i_tready = !busy | (o_tready & last_bit);
    assign load     = i_tvalid & i_tready;
    assign rev_data = WIDTH'(bitrev(MAX_W'(i_tdata), WIDTH));

    assign o_tdata  = sh[WIDTH-1];
    assign o_tvalid = busy;
    assign o_tlast  = busy & last & last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sh    <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        last_n  = last;
        if (load) begin
            sh_n    = reverse_input ? rev_data : i_tdata;
            cnt_n   = CW'(WIDTH - 1);
            last_n  = i_tlast;
            state_n = ST_SHIFT;
        end else if (xfer) begin
            if (!last_bit) begin
                sh_n  = {sh[WIDTH-2:0], 1'b0};
                cnt_n = cnt - CW'(1);
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

`ifdef AXI_SERIALIZER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_sent <= '0;
            pkts_sent  <= '0;
        end else if (xfer & last_bit) begin
            words_sent <= words_sent + STATS_W'(1);
            if (last) pkts_sent <= pkts_sent + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axi_serializer.sv
// Directed bench for axi_serializer: an 8-bit instance for ordering, flow control,
// packets and reset, plus a 32-bit instance checked by a bench-side deserializer.
module tb_axi_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       reverse_input, i_tlast, i_tvalid, i_tready;
    logic [7:0] i_tdata;
    logic       o_tdata, o_tlast, o_tvalid, o_tready;

    logic        r32_tlast, r32_tvalid, r32_tready;
    logic [31:0] r32_tdata;
    logic        s32_tdata, s32_tlast, s32_tvalid;
`ifdef AXI_SERIALIZER_STATS_EN
    logic [15:0] words_sent, pkts_sent, w32, p32;
`endif

    axi_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .reverse_input(reverse_input),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
`ifdef AXI_SERIALIZER_STATS_EN
        , .words_sent(words_sent), .pkts_sent(pkts_sent)
`endif
    );

    axi_serializer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .reverse_input(1'b0),
        .i_tdata(r32_tdata), .i_tlast(r32_tlast), .i_tvalid(r32_tvalid), .i_tready(r32_tready),
        .o_tdata(s32_tdata), .o_tlast(s32_tlast), .o_tvalid(s32_tvalid), .o_tready(1'b1)
`ifdef AXI_SERIALIZER_STATS_EN
        , .words_sent(w32), .pkts_sent(p32)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one word, flip reverse_input mid-word, and check each serial bit.
    task automatic send8(input string tag, input logic [7:0] w, input logic tl,
                         input logic rev, input logic [7:0] exp_bits);
        reverse_input = rev;
        i_tdata  = w;
        i_tlast  = tl;
        i_tvalid = 1'b1;
        chk({tag, "_rdy"}, {31'd0, i_tready}, 32'd1);
        step();
        i_tvalid = 1'b0;
        reverse_input = ~rev;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), {31'd0, o_tvalid}, 32'd1);
            chk($sformatf("%s_bit%0d", tag, k), {31'd0, o_tdata}, {31'd0, exp_bits[7-k]});
            chk($sformatf("%s_last%0d", tag, k), {31'd0, o_tlast}, {31'd0, (tl && k == 7)});
            step();
        end
        chk({tag, "_idle"}, {31'd0, o_tvalid}, 32'd0);
    endtask

    initial begin
        logic [7:0]  words [3];
        logic [7:0]  bp_word;
        logic [31:0] acc;
        logic [31:0] got [2];
        logic        got_last [2];
        int          idx, cyc, nlast, wi;

        rst_n = 1'b0;
        reverse_input = 1'b0;
        i_tdata = 8'h00; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        r32_tdata = 32'h0; r32_tlast = 1'b0; r32_tvalid = 1'b0;

        // Reset state
        #3;
        chk("rst_vld",  {31'd0, o_tvalid}, 32'd0);
        chk("rst_last", {31'd0, o_tlast},  32'd0);
        chk("rst_data", {31'd0, o_tdata},  32'd0);
        chk("rst_rdy",  {31'd0, i_tready}, 32'd1);
`ifdef AXI_SERIALIZER_STATS_EN
        chk("rst_words", {16'd0, words_sent}, 32'd0);
        chk("rst_pkts",  {16'd0, pkts_sent},  32'd0);
`endif
        #9 rst_n = 1'b1;
        step();

        // Ordering: forward with tlast, then reversed without
        send8("fwd", 8'hC1, 1'b1, 1'b0, 8'b1100_0001);
        send8("rev", 8'hC1, 1'b0, 1'b1, 8'b1000_0011);
        reverse_input = 1'b0;

        // Back-to-back 0xFF then 0x00 with i_tvalid held
        i_tdata = 8'hFF; i_tlast = 1'b0; i_tvalid = 1'b1;
        chk("b2b_rdy0", {31'd0, i_tready}, 32'd1);
        step();
        i_tdata = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) i_tvalid = 1'b0;
            chk($sformatf("b2b_vld%0d", k), {31'd0, o_tvalid}, 32'd1);
            chk($sformatf("b2b_bit%0d", k), {31'd0, o_tdata}, {31'd0, (k < 8)});
            chk($sformatf("b2b_rdy%0d", k + 1), {31'd0, i_tready}, {31'd0, (k == 7 || k == 15)});
            step();
        end
        chk("b2b_idle", {31'd0, o_tvalid}, 32'd0);

        // Backpressure: o_tready low on cycles 3..6 of an 0xB4 word with tlast
        bp_word = 8'b1011_0100;
        i_tdata = bp_word; i_tlast = 1'b1; i_tvalid = 1'b1;
        step();
        i_tvalid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            cyc++;
            o_tready = !(cyc >= 3 && cyc <= 6);
            chk($sformatf("bp_vld_c%0d", cyc), {31'd0, o_tvalid}, 32'd1);
            chk($sformatf("bp_bit_c%0d", cyc), {31'd0, o_tdata}, {31'd0, bp_word[7-idx]});
            chk($sformatf("bp_last_c%0d", cyc), {31'd0, o_tlast}, {31'd0, (idx == 7)});
            step();
            if (o_tready) idx++;
        end
        o_tready = 1'b1;
        chk("bp_cycles", cyc, 32'd12);
        chk("bp_idle", {31'd0, o_tvalid}, 32'd0);

        // Packet boundary: three words, tlast on the third
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        wi = 0;
        i_tdata = words[0]; i_tlast = 1'b0; i_tvalid = 1'b1;
        step();
        wi = 1;
        i_tdata = words[1];
        nlast = 0;
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("pkt_bit%0d", k), {31'd0, o_tdata}, {31'd0, words[k/8][7-(k%8)]});
            chk($sformatf("pkt_last%0d", k), {31'd0, o_tlast}, {31'd0, (k == 23)});
            if (o_tlast) nlast++;
            if (i_tready && i_tvalid) begin
                step();
                wi++;
                if (wi < 3) begin
                    i_tdata = words[wi];
                    i_tlast = (wi == 2);
                end else begin
                    i_tvalid = 1'b0;
                    i_tlast = 1'b0;
                end
            end else begin
                step();
            end
        end
        chk("pkt_nlast", nlast, 32'd1);
        chk("pkt_idle", {31'd0, o_tvalid}, 32'd0);
`ifdef AXI_SERIALIZER_STATS_EN
        chk("pkt_words", {16'd0, words_sent}, 32'd8);
        chk("pkt_pkts",  {16'd0, pkts_sent},  32'd3);
`endif

        // Reset mid-word after 3 bits of 0xA5, then 0x3C from its MSB
        i_tdata = 8'hA5; i_tlast = 1'b1; i_tvalid = 1'b1;
        step();
        i_tvalid = 1'b0;
        step(); step(); step();
        chk("mid_vld_pre", {31'd0, o_tvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_vld_async", {31'd0, o_tvalid}, 32'd0);
        chk("mid_last_async", {31'd0, o_tlast}, 32'd0);
        chk("mid_rdy_async", {31'd0, i_tready}, 32'd1);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_vld", {31'd0, o_tvalid}, 32'd0);
        send8("post", 8'h3C, 1'b1, 1'b0, 8'b0011_1100);
`ifdef AXI_SERIALIZER_STATS_EN
        chk("post_words", {16'd0, words_sent}, 32'd1);
        chk("post_pkts",  {16'd0, pkts_sent},  32'd1);
`endif

        // 32-bit loopback through a bench-side deserializer
        r32_tdata = 32'hDEADBEEF; r32_tlast = 1'b1; r32_tvalid = 1'b1;
        step();
        r32_tdata = 32'h01234567; r32_tlast = 1'b0;
        acc = '0;
        got_last[0] = 1'b0; got_last[1] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (!s32_tvalid) chk($sformatf("lb_vld%0d", k), {31'd0, s32_tvalid}, 32'd1);
            acc = {acc[30:0], s32_tdata};
            if (s32_tlast) got_last[k/32] = 1'b1;
            if (k % 32 == 31) got[k/32] = acc;
            if (k == 31) chk("lb_rdy31", {31'd0, r32_tready}, 32'd1);
            step();
            if (k == 31) r32_tvalid = 1'b0;
        end
        chk("lb_word0", got[0], 32'hDEADBEEF);
        chk("lb_word1", got[1], 32'h01234567);
        chk("lb_last0", {31'd0, got_last[0]}, 32'd1);
        chk("lb_last1", {31'd0, got_last[1]}, 32'd0);
        chk("lb_idle", {31'd0, s32_tvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
